ukprom_reader: RTL and testbench
================================

UKPROM_READER -- requirements
Module: ukprom_reader

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: one-cycle request to begin a burst.
REQ-004 SHALL have port start_adr, input, 10 bits: first nibble address, sampled on an accepted start.
REQ-005 SHALL have port byte_count, input, 9 bits: number of bytes in the burst (0..511), sampled on an accepted start.
REQ-006 SHALL have port prom_adr, output, 10 bits: registered address to the nibble PROM.
REQ-007 SHALL have port prom_data, input, 4 bits: PROM read data, valid one cycle after prom_adr (the PROM registers its address).
REQ-008 SHALL have port byte_data, output, 8 bits: assembled byte.
REQ-009 SHALL have port byte_valid, output, 1 bit: byte_data holds a valid byte.
REQ-010 SHALL have port byte_ready, input, 1 bit: consumer accepts the byte.
REQ-011 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse at end of burst.

Function
REQ-013 SHALL implement FSM states IDLE, ADR_HI, ADR_LO, CAPTURE, OUT.
REQ-014 IDLE: start=1 with byte_count≠0 SHALL latch ptr=start_adr and remaining=byte_count, then go to ADR_HI.
REQ-015 IDLE: start=1 with byte_count=0 SHALL pulse done the next cycle and stay in IDLE with no PROM access.
REQ-016 start while busy=1 SHALL be ignored.
REQ-017 ADR_HI: prom_adr SHALL equal ptr, then go to ADR_LO.
REQ-018 ADR_LO: prom_adr SHALL equal ptr+1 (mod 1024); prom_data SHALL be captured as the high nibble; go to CAPTURE.
REQ-019 CAPTURE: prom_data SHALL be captured as the low nibble; byte_data SHALL be {high,low} from the next cycle; byte_valid SHALL be set; ptr SHALL advance by 2 (mod 1024); go to OUT.
REQ-020 OUT: byte_valid=1 and byte_data SHALL stay stable until byte_valid&byte_ready.
REQ-021 Transfer cycle: byte_valid SHALL clear next cycle and remaining SHALL decrement; remaining reaching 0 SHALL pulse done and go to IDLE; otherwise go to ADR_HI.
REQ-022 byte_ready already high when byte_valid rises SHALL transfer in that first OUT cycle.
REQ-023 Address arithmetic SHALL wrap 0x3FF→0x000 with no error indication.
REQ-024 Minimum byte period SHALL be 4 cycles (ADR_HI, ADR_LO, CAPTURE, OUT) with byte_ready held high.
REQ-025 byte_ready while byte_valid=0 SHALL have no effect.
REQ-026 prom_adr SHALL hold its last value in IDLE and OUT.

Reset
REQ-027 reset=1 SHALL force IDLE, prom_adr=0, byte_data=0, byte_valid=0, busy=0, done=0, ptr=0, remaining=0 on the next edge, including mid-burst; a pending byte SHALL be discarded.
REQ-028 reset SHALL take priority over start in the same cycle.

Verification
REQ-029 Bench PROM model: registered read, nib(a)=a[3:0]. Scenario: start_adr=0x010, byte_count=2, byte_ready=1 -> bytes 0x01 then 0x23, done pulse once, busy low after.
REQ-030 Scenario, wrap: start_adr=0x3FE, byte_count=2 -> bytes 0xEF then 0x01; prom_adr sequence 3FE,3FF,000,001.
REQ-031 Scenario, backpressure: byte_count=1, byte_ready=0 for 10 cycles -> byte_valid held, byte_data=start nibbles stable; transfer only on the first cycle with byte_ready=1.
REQ-032 Scenario, zero count: start with byte_count=0 -> done pulse next cycle, byte_valid never set, prom_adr unchanged.
REQ-033 Scenario, start while busy: second start with different start_adr mid-burst -> ignored; output bytes match the first burst only.
REQ-034 Scenario, reset mid-burst: reset asserted during OUT -> byte_valid=0, busy=0 next cycle; a later start runs a clean burst.

Source files
------------

// File: rtl/ukprom_reader.sv
// Nibble-PROM byte reader: fetches two 4-bit PROM words per byte (high nibble first)
// and hands bytes to a valid/ready consumer, one burst per start request.
module ukprom_reader (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] start_adr,
  input  logic [8:0] byte_count,
  output logic [9:0] prom_adr,
  input  logic [3:0] prom_data,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       busy,
  output logic       done
);

  localparam int unsigned AW = 10;
  localparam int unsigned CW = 9;
  localparam int unsigned NW = 4;
  localparam int unsigned BW = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADR_HI,
    S_ADR_LO,
    S_CAPTURE,
    S_OUT
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] remaining_q, remaining_d;
  logic [NW-1:0] hi_q, hi_d;
  logic [AW-1:0] prom_adr_q, prom_adr_d;
  logic [BW-1:0] byte_data_q, byte_data_d;
  logic          byte_valid_q, byte_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Next-state and registered-output logic; the PROM answers one cycle after its address.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    remaining_d  = remaining_q;
    hi_d         = hi_q;
    prom_adr_d   = prom_adr_q;
    byte_data_d  = byte_data_q;
    byte_valid_d = byte_valid_q;
    done_d       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (byte_count != CW'(0)) begin
            ptr_d       = start_adr;
            remaining_d = byte_count;
            prom_adr_d  = start_adr;
            state_d     = S_ADR_HI;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_ADR_HI: begin
        prom_adr_d = AW'(ptr_q + AW'(1));
        state_d    = S_ADR_LO;
      end
      S_ADR_LO: begin
        hi_d    = prom_data;
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        byte_data_d  = {hi_q, prom_data};
        byte_valid_d = 1'b1;
        ptr_d        = AW'(ptr_q + AW'(2));
        state_d      = S_OUT;
      end
      S_OUT: begin
        if (byte_valid_q && byte_ready) begin
          byte_valid_d = 1'b0;
          remaining_d  = CW'(remaining_q - CW'(1));
          if (remaining_q == CW'(1)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            prom_adr_d = ptr_q;
            state_d    = S_ADR_HI;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      remaining_q  <= '0;
      hi_q         <= '0;
      prom_adr_q   <= '0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      remaining_q  <= remaining_d;
      hi_q         <= hi_d;
      prom_adr_q   <= prom_adr_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign prom_adr   = prom_adr_q;
  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_ukprom_reader.sv
// Scoreboard bench for ukprom_reader: bursts are expanded into expected bytes from
// the PROM content rule nib(a)=a[3:0]; a monitor pops and compares on each transfer.
module tb_ukprom_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [9:0] start_adr = '0;
  logic [8:0] byte_count = '0;
  logic [9:0] prom_adr;
  logic [3:0] prom_data = '0;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready = 1'b0;
  logic       busy;
  logic       done;

  ukprom_reader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_adr  (start_adr),
    .byte_count (byte_count),
    .prom_adr   (prom_adr),
    .prom_data  (prom_data),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // PROM model: registered address, each word holds the low nibble of its address
  always @(posedge clk) prom_data <= prom_adr[3:0];

  typedef struct {
    logic [7:0] b;
    bit         last;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [9:0] adr_log[$];
  int         errors = 0;
  int         checks = 0;
  int         done_seen = 0;
  bit         rand_ready = 1'b0;
  bit         prev_hold = 1'b0;
  logic [7:0] prev_data = '0;
  bit         exp_done_next = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event required none/within budget", name);
  endtask

  // Reference: byte i of a burst is {nib(adr+2i), nib(adr+2i+1)} with 10-bit wrap
  function automatic void model_push(input logic [9:0] adr, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      logic [9:0] a;
      logic [9:0] a1;
      exp_t       e;
      a      = 10'((int'(adr) + 2 * i) % 1024);
      a1     = 10'((int'(a) + 1) % 1024);
      e.b    = {a[3:0], a1[3:0]};
      e.last = (i == cnt - 1);
      exp_q.push_back(e);
    end
  endfunction

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      byte_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: transfer checking, hold stability, done after the last byte
  always @(negedge clk) begin
    if (done) done_seen++;
    if (exp_done_next) begin
      chk("done_after_last", 32'(done), 32'd1);
      chk("busy_after_last", 32'(busy), 32'd0);
      exp_done_next = 1'b0;
    end
    if (prev_hold) begin
      chk("hold_valid", 32'(byte_valid), 32'd1);
      chk("hold_data", 32'(byte_data), 32'(prev_data));
    end
    prev_hold = 1'b0;
    if (!reset && byte_valid === 1'b1) begin
      if (byte_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_byte");
        end else begin
          mon_e = exp_q.pop_front();
          chk("byte", 32'(byte_data), 32'(mon_e.b));
          if (mon_e.last) exp_done_next = 1'b1;
        end
      end else begin
        prev_hold = 1'b1;
        prev_data = byte_data;
      end
    end
  end

  task automatic issue(input logic [9:0] adr, input logic [8:0] cnt, input bit accept);
    @(posedge clk); #1;
    start      = 1'b1;
    start_adr  = adr;
    byte_count = cnt;
    if (accept) model_push(adr, int'(cnt));
    @(posedge clk); #1;
    start      = 1'b0;
    start_adr  = 10'($urandom);
    byte_count = 9'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    adr_log.delete();
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy && (adr_log.size() == 0 || adr_log[$] !== prom_adr)) adr_log.push_back(prom_adr);
      if (!busy && exp_q.size() == 0) return;
    end
    fail_now("wait_idle_timeout");
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int         n;
    int         d0;
    logic [9:0] save_adr;
    logic [9:0] wexp[4];
    logic [9:0] ra;
    logic [8:0] rc;

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_prom_adr", 32'(prom_adr), 32'd0);
    chk("rst_byte_data", 32'(byte_data), 32'd0);
    chk("rst_valid", 32'(byte_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // Basic burst with ready high: minimum 4-cycle byte period
    byte_ready = 1'b1;
    issue(10'h010, 9'd2, 1'b1);
    n = 0;
    while (n < 50 && done !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    chk("burst_latency", 32'(n), 32'd9);
    chk("busy_after_burst", 32'(busy), 32'd0);
    chk("q_empty_basic", 32'(exp_q.size()), 32'd0);

    // Address wrap
    issue(10'h3FE, 9'd2, 1'b1);
    wait_idle(60);
    wexp = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    chk("wrap_len", 32'(adr_log.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < adr_log.size()) chk("wrap_adr", 32'(adr_log[i]), 32'(wexp[i]));

    // Backpressure: hold the byte for 10 cycles, transfer on first ready
    byte_ready = 1'b0;
    repeat (2) @(posedge clk);
    issue(10'h1A5, 9'd1, 1'b1);
    n = 0;
    while (n < 20 && byte_valid !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", 32'(byte_valid), 32'd1);
    repeat (10) @(negedge clk);
    chk("bp_data", 32'(byte_data), 32'h56);
    chk("bp_valid_held", 32'(byte_valid), 32'd1);
    @(posedge clk); #1 byte_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_valid_clear", 32'(byte_valid), 32'd0);
    chk("bp_done", 32'(done), 32'd1);

    // Zero byte count: done only, no PROM access
    repeat (2) @(negedge clk);
    save_adr = prom_adr;
    issue(10'h155, 9'd0, 1'b0);
    @(negedge clk);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("zero_done_once", 32'(done), 32'd0);
    chk("zero_prom_adr", 32'(prom_adr), 32'(save_adr));
    chk("zero_valid", 32'(byte_valid), 32'd0);

    // Start while busy is ignored
    rand_ready = 1'b1;
    d0 = done_seen;
    issue(10'h020, 9'd3, 1'b1);
    issue(10'h300, 9'd2, 1'b0);
    wait_idle(300);
    repeat (4) @(negedge clk);
    chk("busy_start_done_cnt", 32'(done_seen - d0), 32'd1);
    chk("busy_start_q", 32'(exp_q.size()), 32'd0);

    // Reset while a byte is pending
    rand_ready = 1'b0;
    @(posedge clk); #1 byte_ready = 1'b0;
    issue(10'h0C4, 9'd3, 1'b1);
    n = 0;
    while (n < 20 && byte_valid !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    chk("rmid_valid", 32'(byte_valid), 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rmid_valid_clr", 32'(byte_valid), 32'd0);
    chk("rmid_busy", 32'(busy), 32'd0);
    chk("rmid_prom_adr", 32'(prom_adr), 32'd0);
    chk("rmid_byte_data", 32'(byte_data), 32'd0);
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b0;
    byte_ready = 1'b1;
    issue(10'h2A7, 9'd3, 1'b1);
    wait_idle(100);

    // Randomized bursts with random backpressure
    rand_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      ra = 10'($urandom);
      rc = 9'($urandom_range(1, 6));
      issue(ra, rc, 1'b1);
      wait_idle(int'(rc) * 60 + 40);
    end
    repeat (3) @(negedge clk);
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
